// File: rtl/axis_bit_spread.sv
// Direct-sequence spreader: each data bit of an AXI-stream symbol is expanded into
// CODE_LENGTH signed +/-1 chips, emitted NUM_PARALLEL chips per master beat.
module axis_bit_spread #(
    parameter int NUM_PARALLEL = 8,
    parameter int CHIP_WIDTH = 2,
    parameter int CODE_LENGTH = 32,
    parameter logic [CODE_LENGTH-1:0] CODE = 32'hB1C3_5A0F,
    parameter int SYMBOL_BITS = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic [SYMBOL_BITS-1:0]               s_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [NUM_PARALLEL*CHIP_WIDTH-1:0]   m_axis_tdata,
    output logic                                 m_axis_tlast
);

    localparam int TOTAL_CHIPS  = SYMBOL_BITS * CODE_LENGTH;
    localparam int BEATS        = TOTAL_CHIPS / NUM_PARALLEL;
    localparam int MASTER_WIDTH = NUM_PARALLEL * CHIP_WIDTH;
    localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [SYMBOL_BITS-1:0]  sym;
    logic                    busy;
    logic [BEAT_W-1:0]       beat;
    logic [TOTAL_CHIPS-1:0]  spread;
    logic [NUM_PARALLEL-1:0] beat_bits [BEATS];
    logic [MASTER_WIDTH-1:0] beat_chips;
    logic                    adv;
    logic                    last_beat;
    logic                    accept;

    // Chip g of the symbol: code chip (MSB first) XNOR the data bit it belongs to.
    for (genvar g = 0; g < TOTAL_CHIPS; g++) begin : g_spread
        assign spread[g] = CODE[CODE_LENGTH-1-(g % CODE_LENGTH)] ~^ sym[g / CODE_LENGTH];
    end

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar k = 0; k < NUM_PARALLEL; k++) begin : g_lane
            assign beat_bits[b][k] = spread[b*NUM_PARALLEL + k];
        end
    end

    // A set chip bit maps to +1, a clear one to -1 (all ones in two's complement).
    for (genvar k = 0; k < NUM_PARALLEL; k++) begin : g_chip
        assign beat_chips[k*CHIP_WIDTH +: CHIP_WIDTH] =
            beat_bits[beat][k] ? CHIP_WIDTH'(1) : {CHIP_WIDTH{1'b1}};
    end

    assign adv           = ~m_axis_tvalid | m_axis_tready;
    assign last_beat     = (beat == LAST_BEAT);
    assign s_axis_tready = rst_n & (~busy | (adv & last_beat));
    assign accept        = s_axis_tvalid & s_axis_tready;

    // A new symbol accepted on the last beat reloads in the same cycle, so
    // back-to-back symbols stream without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym           <= '0;
            busy          <= 1'b0;
            beat          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (busy && adv) begin
                m_axis_tdata  <= beat_chips;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= last_beat;
                if (last_beat) begin
                    busy <= 1'b0;
                end else begin
                    beat <= beat + 1'b1;
                end
            end else if (!busy && adv) begin
                m_axis_tvalid <= 1'b0;
            end

            if (accept) begin
                sym  <= s_axis_tdata;
                busy <= 1'b1;
                beat <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_bit_spread.sv
// Bench for axis_bit_spread: directed steps plus a random-backpressure run, scored
// against a +/-1 product model of the spreading rule.
module tb_axis_bit_spread;

    localparam int NP = 4;
    localparam int CW = 2;
    localparam int CL = 8;
    localparam int SB = 2;
    localparam int BEATS = SB * CL / NP;
    localparam int CODE_V = 'hB1;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_tvalid;
    logic       s_tready;
    logic [1:0] s_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] m_tdata;
    logic       m_tlast;

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int cyc = 0;
    int beat_count = 0;
    int last_count = 0;
    bit mon_en = 0;
    bit rnd_mode = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data;
    logic prev_last;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    hs_cyc[$];

    axis_bit_spread #(
        .NUM_PARALLEL(NP),
        .CHIP_WIDTH(CW),
        .CODE_LENGTH(CL),
        .CODE(8'hB1),
        .SYMBOL_BITS(SB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each chip is the product of the data bit and the code chip, both taken as +/-1.
    function automatic void modelSymbol(input logic [1:0] sym);
        int chips[$];
        beat_t bt;
        int data_bit;
        int code_bit;
        for (int i = 0; i < SB; i++) begin
            data_bit = (int'(sym) >> i) & 1;
            for (int j = 0; j < CL; j++) begin
                code_bit = (CODE_V >> (CL - 1 - j)) & 1;
                chips.push_back((data_bit ? 1 : -1) * (code_bit ? 1 : -1));
            end
        end
        for (int b = 0; b < BEATS; b++) begin
            bt.data = 8'h00;
            bt.last = (b == BEATS - 1);
            for (int k = 0; k < NP; k++) begin
                bt.data = bt.data | (8'(chips[b*NP + k] & 3) << (2 * k));
            end
            exp_q.push_back(bt);
        end
    endfunction

    task automatic applyStimulus(input logic [1:0] sym);
        int waited = 0;
        bit ok = 0;
        s_tvalid = 1'b1;
        s_tdata  = sym;
        while (waited < 500) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            checkOutput("s_accept_timeout", 32'(s_tready), 32'd1);
        end else begin
            @(posedge clk);
            modelSymbol(sym);
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic waitBeats(input int n);
        int w = 0;
        while (beat_count < n && w < 3000) begin
            @(posedge clk);
            w++;
        end
        #1;
        checkOutput("beat_wait", 32'(beat_count), 32'(n));
    endtask

    // Scoreboard: every handshake is matched against the model, and a stalled beat must not change.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (mon_en) begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(m_tvalid), 32'd1);
                checkOutput("stall_data", 32'(m_tdata), 32'(prev_data));
                checkOutput("stall_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                obs_q.push_back({m_tdata, m_tlast});
                hs_cyc.push_back(cyc);
                beat_count++;
                if (m_tlast) last_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat_data", 32'(m_tdata), 32'(e.data));
                    checkOutput("beat_last", 32'(m_tlast), 32'(e.last));
                end
            end
            prev_stall = m_tvalid & ~m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end else begin
            prev_stall = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_mode) m_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] t1 [4];
        logic [7:0] t2 [8];
        int w;
        t1 = '{8'h5D, 8'h7F, 8'hF7, 8'hD5};
        t2 = '{8'h5D, 8'h7F, 8'h5D, 8'h7F, 8'hF7, 8'hD5, 8'hF7, 8'hD5};

        rst_n = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = 2'b00;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_tdata", 32'(m_tdata), 32'd0);
        checkOutput("rst_tlast", 32'(m_tlast), 32'd0);
        checkOutput("rst_s_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_s_tready", 32'(s_tready), 32'd1);
        mon_en = 1;

        $display("[TB] single symbol 2'b01");
        @(posedge clk);
        #1;
        applyStimulus(2'b01);
        @(negedge clk);
        checkOutput("lat_pre_valid", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        checkOutput("lat_first_valid", 32'(m_tvalid), 32'd1);
        checkOutput("lat_first_data", 32'(m_tdata), 32'h5D);
        waitBeats(4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_data", 32'(obs_q[i].data), 32'(t1[i]));
            checkOutput("t1_last", 32'(obs_q[i].last), 32'(i == 3));
        end
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_tvalid", 32'(m_tvalid), 32'd0);
            checkOutput("idle_s_tready", 32'(s_tready), 32'd1);
        end

        $display("[TB] back-to-back 2'b11, 2'b00");
        @(posedge clk);
        #1;
        obs_q.delete();
        hs_cyc.delete();
        beat_count = 0;
        last_count = 0;
        applyStimulus(2'b11);
        applyStimulus(2'b00);
        waitBeats(8);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_data", 32'(obs_q[i].data), 32'(t2[i]));
            checkOutput("t2_last", 32'(obs_q[i].last), 32'(i == 3 || i == 7));
        end
        for (int i = 1; i < 8; i++) begin
            checkOutput("t2_no_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd1);
        end

        $display("[TB] random backpressure, 100 symbols");
        @(posedge clk);
        #1;
        beat_count = 0;
        last_count = 0;
        rnd_mode = 1;
        for (int n = 0; n < 100; n++) begin
            applyStimulus(2'($urandom_range(0, 3)));
        end
        waitBeats(400);
        rnd_mode = 0;
        @(posedge clk);
        #2 m_tready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rnd_beats", 32'(beat_count), 32'd400);
        checkOutput("rnd_lasts", 32'(last_count), 32'd100);
        checkOutput("rnd_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset during stalled beat 2");
        @(posedge clk);
        #1;
        beat_count = 0;
        m_tready = 1'b1;
        applyStimulus(2'b01);
        w = 0;
        while (beat_count < 2 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        m_tready = 1'b0;
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("mid_rst_tdata", 32'(m_tdata), 32'd0);
        checkOutput("mid_rst_tlast", 32'(m_tlast), 32'd0);
        checkOutput("mid_rst_s_tready", 32'(s_tready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("post_rst_idle", 32'(m_tvalid), 32'd0);
            checkOutput("post_rst_ready", 32'(s_tready), 32'd1);
        end
        @(posedge clk);
        #1;
        obs_q.delete();
        beat_count = 0;
        mon_en = 1;
        applyStimulus(2'b01);
        waitBeats(4);
        checkOutput("post_rst_first", 32'(obs_q[0].data), 32'h5D);
        repeat (2) @(negedge clk);
        checkOutput("post_rst_pending", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
